fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the team's dual-port RAM and drives its port interface: port A is the write port and port B is the read port.
- Maintains the read/write pointers, occupancy count and status flags.
- Returns read data taken from the RAM's port-B output with a one-cycle valid strobe.
- Steers addresses so the RAM's same-address collision case is never hit on an intended write.

---
 rtl/fifo_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller placed directly upstream of a
// dual-port RAM. Port A of the RAM is the write port and port B is the read
// port. This block keeps the pointers, the occupancy count and the status
// flags. Read data comes back from the RAM's registered port-B output
// together with a one-cycle pop_valid strobe.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   push, push_data       write request and write data
//   pop                   read request
//   pop_data, pop_valid   read data, valid the cycle after an accepted pop
//   full, empty           count == DEPTH / count == 0
//   almost_full           count >= AF_LEVEL
//   count                 current occupancy, 0..DEPTH
//   overflow, underflow   sticky error flags: push while full, pop while empty
//   ram_*_a               RAM write port (we, addr, din)
//   ram_*_b, ram_dout_b   RAM read port (we and din tied low, addr, dout)
module fifo_ctrl #(
  parameter int ADD_WIDTH  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,  // must equal 2**ADD_WIDTH
  parameter int AF_LEVEL   = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADD_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_we_a,
  output logic [ADD_WIDTH-1:0]  ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_we_b,
  output logic [ADD_WIDTH-1:0]  ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  localparam logic [ADD_WIDTH:0] FULL_COUNT = (ADD_WIDTH + 1)'(DEPTH);
  localparam logic [ADD_WIDTH:0] AF_COUNT   = (ADD_WIDTH + 1)'(AF_LEVEL);

  logic [ADD_WIDTH-1:0] wr_ptr;
  logic [ADD_WIDTH-1:0] rd_ptr;
  logic                 push_acc;
  logic                 pop_acc;

  // Flags decode straight from the count register, so they are glitch-free
  // with respect to push/pop and read correctly during reset.
  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_COUNT);

  // A push while full is refused even if a pop is accepted in the same cycle.
  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;

  assign ram_we_a   = push_acc;
  assign ram_addr_a = wr_ptr;
  assign ram_din_a  = push_data;
  assign ram_we_b   = 1'b0;
  assign ram_din_b  = '0;

  // When not reading, park port B one slot ahead of the write pointer so the
  // two RAM addresses never collide on a write, even with the FIFO empty
  // (where rd_ptr == wr_ptr). On a simultaneous push/pop the FIFO is neither
  // empty nor full, so rd_ptr != wr_ptr already.
  // NOTE: every output of an always_comb gets a default before any branch so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ram_addr_b = wr_ptr + ADD_WIDTH'(1);
    if (pop_acc) ram_addr_b = rd_ptr;
  end

  // The RAM registers the word at rd_ptr on the pop edge; it is visible on
  // ram_dout_b in the following cycle, aligned with pop_valid.
  assign pop_data = ram_dout_b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Pointers roll over naturally from DEPTH-1 to 0.
      if (push_acc) wr_ptr <= wr_ptr + ADD_WIDTH'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + ADD_WIDTH'(1);

      unique case ({push_acc, pop_acc})
        2'b10:   count <= count + (ADD_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADD_WIDTH + 1)'(1);
        default: count <= count;
      endcase

      pop_valid <= pop_acc;
      if (push && full) overflow  <= 1'b1;
      if (pop && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl. A behavioural
// dual-port RAM (registered port-B read) is attached to the RAM ports so the
// data path is exercised end to end.
module tb_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic          ram_we_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_din_b;
  logic [DW-1:0] ram_dout_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .AF_LEVEL(14)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .pop_data    (pop_data),
    .pop_valid   (pop_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .ram_we_a    (ram_we_a),
    .ram_addr_a  (ram_addr_a),
    .ram_din_a   (ram_din_a),
    .ram_we_b    (ram_we_b),
    .ram_addr_b  (ram_addr_b),
    .ram_din_b   (ram_din_b),
    .ram_dout_b  (ram_dout_b)
  );

  // Dual-port RAM model: synchronous writes on both ports, registered read
  // on port B.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    ram_dout_b <= mem[ram_addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later, release.
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic q);
    push = p;
    push_data = d;
    pop = q;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(almost_full), 0);
    check("rst_pop_valid", 32'(pop_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // ---- 1: reset, three pushes, three pops
    @(posedge clk);
    #1;
    do_reset();
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    check("t1_count3", 32'(count), 3);
    check("t1_not_empty", 32'(empty), 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("t1_valid0", 32'(pop_valid), 1);
    check("t1_data0", 32'(pop_data), 32'h11);
    cyc(1'b0, 8'h00, 1'b1);
    check("t1_valid1", 32'(pop_valid), 1);
    check("t1_data1", 32'(pop_data), 32'h22);
    cyc(1'b0, 8'h00, 1'b1);
    check("t1_valid2", 32'(pop_valid), 1);
    check("t1_data2", 32'(pop_data), 32'h33);
    check("t1_count0", 32'(count), 0);
    check("t1_empty", 32'(empty), 1);
    cyc(1'b0, 8'h00, 1'b0);
    check("t1_valid_drop", 32'(pop_valid), 0);

    // ---- 2: fill from pointer 0, flags, overflow
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      check("t2_count", 32'(count), 32'(i + 1));
      check("t2_af", 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      check("t2_full", 32'(full), (i + 1 == 16) ? 32'd1 : 32'd0);
    end
    push = 1'b1;
    push_data = 8'hAA;
    #1;
    check("t2_we_when_full", 32'(ram_we_a), 0);
    cyc(1'b1, 8'hAA, 1'b0);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_count_full", 32'(count), 16);
    // Push refused while full even with a concurrent pop.
    cyc(1'b1, 8'hAB, 1'b1);
    check("t2_pushpop_full_count", 32'(count), 15);
    check("t2_pushpop_full_data", 32'(pop_data), 32'h00);

    // ---- 3: drain in order (first word already taken), wrap, reuse slot 0
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check("t3_valid", 32'(pop_valid), 1);
      check("t3_data", 32'(pop_data), 32'(i));
    end
    check("t3_empty", 32'(empty), 1);
    push = 1'b1;
    push_data = 8'h5A;
    #1;
    check("t3_wrap_addr_a", 32'(ram_addr_a), 0);
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("t3_wrap_valid", 32'(pop_valid), 1);
    check("t3_wrap_data", 32'(pop_data), 32'h5A);

    // ---- 4: steady state at count 5 with simultaneous push and pop
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    check("t4_count5", 32'(count), 5);
    for (int i = 0; i < 10; i++) begin
      push = 1'b1;
      push_data = 8'(8'h25 + i);
      pop = 1'b1;
      #1;
      check("t4_addr_diff", 32'(ram_addr_a != ram_addr_b), 1);
      check("t4_we_a", 32'(ram_we_a), 1);
      cyc(1'b1, 8'(8'h25 + i), 1'b1);
      check("t4_valid", 32'(pop_valid), 1);
      check("t4_data", 32'(pop_data), 32'(8'h20 + i));
      check("t4_count", 32'(count), 5);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check("t4_drain", 32'(pop_data), 32'(8'h2A + i));
    end
    check("t4_empty", 32'(empty), 1);

    // ---- 5: underflow, push into empty FIFO at pointer 0
    do_reset();
    cyc(1'b0, 8'h00, 1'b1);
    check("t5_no_valid", 32'(pop_valid), 0);
    check("t5_underflow", 32'(underflow), 1);
    check("t5_count", 32'(count), 0);
    push = 1'b1;
    push_data = 8'h77;
    #1;
    check("t5_we_a", 32'(ram_we_a), 1);
    check("t5_addr_a", 32'(ram_addr_a), 0);
    check("t5_addr_b", 32'(ram_addr_b), 1);
    check("t5_din_a", 32'(ram_din_a), 32'h77);
    check("t5_we_b", 32'(ram_we_b), 0);
    cyc(1'b1, 8'h77, 1'b0);
    check("t5_ram_stored", 32'(mem[0]), 32'h77);
    check("t5_not_empty", 32'(empty), 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("t5_valid", 32'(pop_valid), 1);
    check("t5_data", 32'(pop_data), 32'h77);
    check("t5_underflow_sticky", 32'(underflow), 1);

    // ---- 6: reset in mid-stream with a pop_valid pending
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    check("t6_count8", 32'(count), 8);
    cyc(1'b0, 8'h00, 1'b1);
    check("t6_valid_before", 32'(pop_valid), 1);
    do_reset();
    cyc(1'b1, 8'h99, 1'b0);
    check("t6_count1", 32'(count), 1);
    cyc(1'b0, 8'h00, 1'b1);
    check("t6_valid", 32'(pop_valid), 1);
    check("t6_data", 32'(pop_data), 32'h99);
    check("t6_empty", 32'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
